band_la_scheduler: RTL
======================

// Module: band_la_scheduler
// PURPOSE
//  Shares one iterative 2x2 eigen solver among the BANDS per-band correlation triplets (r11,r12,r22).
//  Triplets arrive in bursts, one per band, after every accumulation dump. The block buffers them in a FIFO.
//  It issues them to the solver one at a time with a start/done handshake and guards each solve with a watchdog.
//  It also tracks per-frame band completion. It sits between the accumulator cast/delay stage and the eigen solver.
// PARAMETERS
//  DIN_WIDTH      16    width of r11/r12/r22 (signed, point unchanged, passed through)
//  BANDS          4     bands per accumulation frame; BW=$clog2(BANDS)
//  FIFO_DEPTH     8     triplet FIFO entries (power of 2); CW=$clog2(FIFO_DEPTH+1)
//  TIMEOUT_CYCLES 1024  max cycles from la_start to la_done before abort
// PORTS
//  clk           in   1              clock
//  rst_n         in   1              asynchronous reset, active-low
//  r11,r12,r22   in   DIN_WIDTH      correlation triplet
//  band_in       in   BW             band index of the triplet
//  din_valid     in   1              triplet valid; no backpressure
//  la_ready      in   1              solver idle and able to accept a start
//  la_done       in   1              solver result valid (1-cycle pulse)
//  la_r11,la_r12,la_r22 out DIN_WIDTH  registered triplet to solver; held stable from la_start to done/abort
//  la_band       out  BW             band index to solver
//  la_start      out  1              1-cycle start pulse
//  la_abort      out  1              1-cycle abort pulse on timeout
//  clear_flags   in   1              synchronous clear of sticky flags and frame mask
//  fifo_count    out  CW             occupied entries
//  fifo_full     out  1              fifo_count==FIFO_DEPTH
//  overflow      out  1              sticky: triplet dropped
//  timeout       out  1              sticky: watchdog expired
//  frame_done    out  1              1-cycle pulse when all BANDS bands have completed
// BEHAVIOUR
//  - Reset: all outputs 0; FIFO empty; FSM=IDLE; frame mask=0; watchdog=0.
//  - FIFO write: din_valid && (!full || pop this cycle). If full with no pop, drop the new triplet and set overflow.
//    Storage is unchanged on a drop.
//  - FSM IDLE: when !empty && la_ready, pop the head into the la_* registers and go to ISSUE.
//  - FSM ISSUE: la_start=1 for this cycle only; clear the watchdog; go to WAIT.
//  - FSM WAIT: increment the watchdog each cycle.
//    - On la_done: set mask[la_band]; go to IDLE.
//    - When the watchdog reaches TIMEOUT_CYCLES-1 with no la_done: la_abort=1 for one cycle, set timeout, go to IDLE.
//      The aborted band is not marked.
//  - la_done and timeout in the same cycle: la_done wins; no abort.
//  - la_done outside WAIT is ignored.
//  - Latency: din_valid in cycle N with FIFO empty, FSM IDLE and la_ready=1 -> la_start high in cycle N+2.
//  - Back-to-back: the next la_start comes no earlier than 2 cycles after la_done.
//  - Frame: when the mask becomes all-ones (first BANDS bits), frame_done pulses the following cycle and the mask clears.
//  - A band already set in the mask that completes again leaves the mask unchanged.
//  - clear_flags: clears overflow, timeout and the mask next edge. It does not affect the FIFO or FSM.
//    If clear_flags and a set event occur in the same cycle, the set wins.
//  - Async reset mid-solve: return to IDLE immediately; no abort pulse.
//  - Pointers wrap modulo FIFO_DEPTH; fifo_count is exact 0..FIFO_DEPTH.
// CONFIGURATION
//  BAND_LA_SCHED_STATS_EN defined: adds outputs issued_cnt, drop_cnt and timeout_cnt, each [31:0].
//   - Counting: issued_cnt +1 per la_start; drop_cnt +1 per dropped triplet; timeout_cnt +1 per la_abort.
//   - All three saturate at 2^32-1 and reset to 0 on rst_n; clear_flags does not clear them.
//  Undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  - Reset: hold rst_n=0 with din_valid=1 -> all outputs 0, fifo_count=0; release -> la_start 2 cycles after the first valid.
//  - Burst: 4 triplets bands 0..3 on consecutive cycles, la_done 10 cycles after each start.
//    Expect 4 la_start pulses in band order 0,1,2,3, fifo_count peak 3, and frame_done 1 cycle after the 4th la_done.
//  - Overflow (DEPTH=8, la_ready=0): push 10 triplets -> fifo_full=1, overflow=1, entries 0..7 retained.
//    Raise la_ready -> bands issue from the first 8 values in order.
//  - Full+pop same cycle: FIFO full and a pop in the cycle of din_valid -> triplet accepted, overflow stays 0, count stays 8.
//  - Timeout (TIMEOUT_CYCLES=16): never send la_done -> la_abort 16 cycles after la_start, timeout=1.
//    Mask bit stays clear; the next entry issues afterwards.
//  - Stats (STATS_EN): repeat the overflow and timeout scenarios -> drop_cnt=2, timeout_cnt=1, issued_cnt matches pulses.

Source files
------------

// File: rtl/band_la_scheduler.sv
// band_la_scheduler
//   Shares one iterative 2x2 eigen solver among BANDS per-band correlation
//   triplets. Triplets are buffered in a FIFO and issued one at a time with a
//   start/done handshake. A watchdog aborts a solve that runs too long. The
//   block also tracks which bands of the current frame have completed.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   r11, r12, r22, band_in   incoming triplet and its band index
//   din_valid                triplet valid (no backpressure)
//   la_ready, la_done        solver idle / solver result valid pulse
//   la_r11/12/22, la_band    triplet held for the solver from start to done/abort
//   la_start, la_abort       one-cycle start and watchdog-abort pulses
//   clear_flags              synchronous clear of sticky flags and frame mask
//   fifo_count, fifo_full    FIFO occupancy
//   overflow, timeout        sticky drop / watchdog flags
//   frame_done               one-cycle pulse when every band has completed
//
// Optional feature: define BAND_LA_SCHED_STATS_EN to add saturating counters
//   issued_cnt, drop_cnt and timeout_cnt (cleared only by rst_n).
module band_la_scheduler #(
    parameter int DIN_WIDTH      = 16,
    parameter int BANDS          = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int BW = (BANDS > 1) ? $clog2(BANDS) : 1,
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIN_WIDTH-1:0] r11,
    input  logic [DIN_WIDTH-1:0] r12,
    input  logic [DIN_WIDTH-1:0] r22,
    input  logic [BW-1:0]        band_in,
    input  logic                 din_valid,
    input  logic                 la_ready,
    input  logic                 la_done,
    output logic [DIN_WIDTH-1:0] la_r11,
    output logic [DIN_WIDTH-1:0] la_r12,
    output logic [DIN_WIDTH-1:0] la_r22,
    output logic [BW-1:0]        la_band,
    output logic                 la_start,
    output logic                 la_abort,
    input  logic                 clear_flags,
    output logic [CW-1:0]        fifo_count,
    output logic                 fifo_full,
    output logic                 overflow,
    output logic                 timeout,
    output logic                 frame_done
`ifdef BAND_LA_SCHED_STATS_EN
    ,
    output logic [31:0]          issued_cnt,
    output logic [31:0]          drop_cnt,
    output logic [31:0]          timeout_cnt
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int EW = BW + 3 * DIN_WIDTH;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    state_e            state_q, state_d;
    logic [WW-1:0]     wd_q, wd_d;
    logic [EW-1:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [EW-1:0]     la_q, la_d;
    logic              ov_q, ov_d, to_q, to_d, frame_q, frame_d;
    logic [BANDS-1:0]  mask_q, mask_d, mask_set, band_onehot;
    logic              empty, full, pop, push, drop, done_ok, abort_now;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign pop   = (state_q == IDLE) && !empty && la_ready;
    // A write into a full FIFO is still accepted when the head leaves the same cycle.
    assign push  = din_valid && (!full || pop);
    assign drop  = din_valid && full && !pop;

    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        la_start  = 1'b0;
        la_abort  = 1'b0;
        done_ok   = 1'b0;
        abort_now = 1'b0;
        case (state_q)
            IDLE: if (pop) state_d = ISSUE;
            ISSUE: begin
                la_start = 1'b1;
                wd_d     = '0;
                state_d  = WAIT;
            end
            WAIT: begin
                wd_d = wd_q + 1'b1;
                // A done arriving on the last watchdog cycle takes priority over the abort.
                if (la_done) begin
                    done_ok = 1'b1;
                    state_d = IDLE;
                end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
                    la_abort  = 1'b1;
                    abort_now = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        la_d     = la_q;
        if (push) wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            la_d     = mem_q[rd_ptr_q];
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        band_onehot = '0;
        for (int unsigned i = 0; i < BANDS; i++) band_onehot[i] = (la_band == BW'(i));
        // Clear is applied first so a same-cycle set survives it.
        mask_set = (clear_flags ? '0 : mask_q) | (done_ok ? band_onehot : '0);
        frame_d  = &mask_set;
        mask_d   = frame_d ? '0 : mask_set;
        ov_d     = (ov_q && !clear_flags) || drop;
        to_d     = (to_q && !clear_flags) || abort_now;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {band_in, r11, r12, r22};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wd_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            la_q     <= '0;
            ov_q     <= 1'b0;
            to_q     <= 1'b0;
            frame_q  <= 1'b0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            wd_q     <= wd_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            la_q     <= la_d;
            ov_q     <= ov_d;
            to_q     <= to_d;
            frame_q  <= frame_d;
            mask_q   <= mask_d;
        end
    end

    assign {la_band, la_r11, la_r12, la_r22} = la_q;
    assign fifo_count = count_q;
    assign fifo_full  = full;
    assign overflow   = ov_q;
    assign timeout    = to_q;
    assign frame_done = frame_q;

`ifdef BAND_LA_SCHED_STATS_EN
    logic [31:0] issued_q, drop_q, tmo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q <= '0;
            drop_q   <= '0;
            tmo_q    <= '0;
        end else begin
            if (la_start && issued_q != '1) issued_q <= issued_q + 1'b1;
            if (drop && drop_q != '1)       drop_q   <= drop_q + 1'b1;
            if (la_abort && tmo_q != '1)    tmo_q    <= tmo_q + 1'b1;
        end
    end

    assign issued_cnt  = issued_q;
    assign drop_cnt    = drop_q;
    assign timeout_cnt = tmo_q;
`endif

endmodule
